// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: IR/zero/memory-ready inputs to the sequencer,
// mux selects, write enables, status pulses and the retired counter back out.
interface multicycle_control_unit_if #(
    parameter int ICNT_W = 32
);
    logic              enable;
    logic [6:0]        opcode;
    logic              zero;
    logic              mem_ready;
    logic              mem_req;
    logic              mem_we;
    logic              iord;
    logic              ir_write;
    logic              pc_write;
    logic [1:0]        pc_src;
    logic              alu_src_a;
    logic [1:0]        alu_src_b;
    logic [1:0]        alu_op;
    logic              reg_write;
    logic              mem_2_reg;
    logic              illegal_instr;
    logic              bus_error;
    logic [ICNT_W-1:0] instr_retired;

    modport master (
        input  enable, opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_2_reg,
               illegal_instr, bus_error, instr_retired
    );

    modport slave (
        output enable, opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_2_reg,
               illegal_instr, bus_error, instr_retired
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for a shared-memory multicycle datapath with memory wait/timeout
// handling, illegal-opcode flagging and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5,
    parameter int ICNT_W  = 32
) (
    input logic                       clk,
    input logic                       arst,
    multicycle_control_unit_if.master bus
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU,
        S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP
    } state_t;

    state_t            state_q, state_d, after_retire;
    logic [TW-1:0]     wait_q, wait_d;
    logic [ICNT_W-1:0] retired_q, retired_d;
    logic              is_store_q, is_store_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic              retire;
    logic              mem_state;

    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        is_store_d   = is_store_q;
        illegal_d    = 1'b0;
        bus_err_d    = 1'b0;
        retire       = 1'b0;
        mem_state    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        after_retire = bus.enable ? S_FETCH : S_IDLE;

        // An unanswered memory access holds the state; the watchdog abandons it.
        if (mem_state && !bus.mem_ready) begin
            wait_d = wait_q + 1'b1;
            if (wait_q == TW'(TIMEOUT - 1)) begin
                state_d   = S_IDLE;
                bus_err_d = 1'b1;
                wait_d    = '0;
            end
        end else begin
            case (state_q)
                S_IDLE:     if (bus.enable) state_d = S_FETCH;
                S_FETCH:    state_d = S_DECODE;
                S_DECODE: begin
                    is_store_d = (bus.opcode == OP_STORE);
                    case (bus.opcode)
                        OP_R:             state_d = S_EXEC_R;
                        OP_I:             state_d = S_EXEC_I;
                        OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                        OP_BR:            state_d = S_BRANCH;
                        OP_JAL:           state_d = S_JUMP;
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = after_retire;
                        end
                    endcase
                end
                S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
                S_MEM_ADDR: state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   state_d = S_WB_MEM;
                S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP: begin
                    retire  = 1'b1;
                    state_d = after_retire;
                end
                default:    state_d = S_IDLE;
            endcase
        end
        retired_d = retired_q + {{(ICNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            retired_q  <= '0;
            is_store_q <= 1'b0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            retired_q  <= retired_d;
            is_store_q <= is_store_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Control decode sees only the state register, plus mem_ready/zero where a strobe depends on them.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.iord      = 1'b0;
        bus.ir_write  = 1'b0;
        bus.pc_write  = 1'b0;
        bus.pc_src    = 2'b00;
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = 2'b00;
        bus.alu_op    = 2'b00;
        bus.reg_write = 1'b0;
        bus.mem_2_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE:   bus.alu_src_b = 2'b10;
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = 2'b11;
            end
            S_WB_ALU:   bus.reg_write = 1'b1;
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            S_WB_MEM: begin
                bus.reg_write = 1'b1;
                bus.mem_2_reg = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.iord    = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                bus.pc_write  = bus.zero;
            end
            S_JUMP: begin
                bus.pc_src   = 2'b10;
                bus.pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.illegal_instr = illegal_q;
    assign bus.bus_error     = bus_err_q;
    assign bus.instr_retired = retired_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each cycle's stimulus pushes the expected control word, which is
// popped and compared at the following falling edge.
module tb_multicycle_control_unit;
    localparam int ICNT_W = 4;

    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ICNT_W(ICNT_W)) bus ();

    multicycle_control_unit #(.TIMEOUT(4), .TW(3), .ICNT_W(ICNT_W)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    logic [15:0] ctrl;
    assign ctrl = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
                   bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write, bus.mem_2_reg,
                   bus.illegal_instr, bus.bus_error};

    function automatic logic [15:0] mk(input logic mreq, input logic mwe, input logic io,
                                       input logic irw, input logic pcw, input logic [1:0] pcs,
                                       input logic a, input logic [1:0] b, input logic [1:0] op,
                                       input logic rw, input logic m2r, input logic ill,
                                       input logic be);
        return {mreq, mwe, io, irw, pcw, pcs, a, b, op, rw, m2r, ill, be};
    endfunction

    localparam logic [15:0] C_IDLE     = 16'h0000;
    localparam logic [15:0] C_FETCH_W  = mk(1,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0,0);
    localparam logic [15:0] C_FETCH_R  = mk(1,0,0,1,1,2'b00,0,2'b01,2'b00,0,0,0,0);
    localparam logic [15:0] C_DECODE   = mk(0,0,0,0,0,2'b00,0,2'b10,2'b00,0,0,0,0);
    localparam logic [15:0] C_EXEC_R   = mk(0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0);
    localparam logic [15:0] C_EXEC_I   = mk(0,0,0,0,0,2'b00,1,2'b10,2'b11,0,0,0,0);
    localparam logic [15:0] C_WB_ALU   = mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,0,0);
    localparam logic [15:0] C_MEM_ADDR = mk(0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0);
    localparam logic [15:0] C_MEM_RD   = mk(1,0,1,0,0,2'b00,0,2'b00,2'b00,0,0,0,0);
    localparam logic [15:0] C_WB_MEM   = mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,1,0,0);
    localparam logic [15:0] C_MEM_WR   = mk(1,1,1,0,0,2'b00,0,2'b00,2'b00,0,0,0,0);
    localparam logic [15:0] C_BR_NT    = mk(0,0,0,0,0,2'b01,1,2'b00,2'b01,0,0,0,0);
    localparam logic [15:0] C_BR_T     = mk(0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0,0);
    localparam logic [15:0] C_JUMP     = mk(0,0,0,0,1,2'b10,0,2'b00,2'b00,0,0,0,0);
    localparam logic [15:0] C_ILL      = 16'h0002;
    localparam logic [15:0] C_BERR     = 16'h0001;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_J = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'h7F;

    typedef struct packed {
        logic        en;
        logic [6:0]  op;
        logic        z;
        logic        rdy;
        logic [15:0] exp;
    } step_t;

    step_t       plan[$];
    logic [15:0] sb[$];
    logic [15:0] exp_v;
    logic [ICNT_W-1:0] exp_cnt = '0;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic add(input logic en, input logic [6:0] op, input logic z, input logic rdy,
                       input logic [15:0] e);
        step_t s;
        s.en = en; s.op = op; s.z = z; s.rdy = rdy; s.exp = e;
        plan.push_back(s);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (ctrl !== C_IDLE || bus.instr_retired !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ctrl=%b cnt=%0d required ctrl=%b cnt=0", ctrl, bus.instr_retired, C_IDLE);
        end
        @(posedge clk); #1;
        arst = 1'b0;
        $display("test_reset: ctrl=%b cnt=%0d", ctrl, bus.instr_retired);
    endtask

    task automatic test_alu_r();
        add(1, OP_R, 0, 1, C_IDLE);   add(1, OP_R, 0, 1, C_FETCH_R);
        add(1, OP_R, 0, 1, C_DECODE); add(1, OP_R, 0, 1, C_EXEC_R);
        add(0, OP_R, 0, 1, C_WB_ALU); add(0, OP_R, 0, 1, C_IDLE);
        for (int i = 0; i < plan.size(); i++) begin
            bus.enable = plan[i].en; bus.opcode = plan[i].op; bus.zero = plan[i].z; bus.mem_ready = plan[i].rdy;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_checks++;
            if (ctrl !== exp_v) begin n_fail++; $display("FAIL alu_r step %0d: ctrl=%b required %b", i, ctrl, exp_v); end
            @(posedge clk); #1;
        end
        plan.delete();
        exp_cnt = exp_cnt + 1'b1;
        n_checks++;
        if (bus.instr_retired !== exp_cnt) begin n_fail++; $display("FAIL alu_r_count: cnt=%0d required %0d", bus.instr_retired, exp_cnt); end
        $display("test_alu_r: cnt=%0d", bus.instr_retired);
    endtask

    task automatic test_load_store();
        add(1, OP_LD, 0, 1, C_IDLE);     add(1, OP_LD, 0, 1, C_FETCH_R);
        add(1, OP_LD, 0, 1, C_DECODE);   add(1, OP_LD, 0, 1, C_MEM_ADDR);
        add(1, OP_LD, 0, 0, C_MEM_RD);   add(1, OP_LD, 0, 0, C_MEM_RD);
        add(1, OP_LD, 0, 0, C_MEM_RD);   add(1, OP_LD, 0, 1, C_MEM_RD);
        add(0, OP_LD, 0, 0, C_WB_MEM);   add(1, OP_ST, 0, 1, C_IDLE);
        add(1, OP_ST, 0, 1, C_FETCH_R);  add(1, OP_ST, 0, 1, C_DECODE);
        add(1, OP_ST, 0, 1, C_MEM_ADDR); add(0, OP_ST, 0, 1, C_MEM_WR);
        add(0, OP_ST, 0, 1, C_IDLE);
        for (int i = 0; i < plan.size(); i++) begin
            bus.enable = plan[i].en; bus.opcode = plan[i].op; bus.zero = plan[i].z; bus.mem_ready = plan[i].rdy;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_checks++;
            if (ctrl !== exp_v) begin n_fail++; $display("FAIL load_store step %0d: ctrl=%b required %b", i, ctrl, exp_v); end
            @(posedge clk); #1;
        end
        plan.delete();
        exp_cnt = exp_cnt + 2'd2;
        n_checks++;
        if (bus.instr_retired !== exp_cnt) begin n_fail++; $display("FAIL load_store_count: cnt=%0d required %0d", bus.instr_retired, exp_cnt); end
        $display("test_load_store: cnt=%0d", bus.instr_retired);
    endtask

    task automatic test_branch_jump();
        add(1, OP_BR, 0, 1, C_IDLE);    add(1, OP_BR, 0, 1, C_FETCH_R);
        add(1, OP_BR, 0, 1, C_DECODE);  add(1, OP_BR, 0, 1, C_BR_NT);
        add(1, OP_BR, 1, 1, C_FETCH_R); add(1, OP_BR, 1, 1, C_DECODE);
        add(1, OP_BR, 1, 1, C_BR_T);    add(1, OP_J, 0, 1, C_FETCH_R);
        add(1, OP_J, 0, 1, C_DECODE);   add(0, OP_J, 0, 1, C_JUMP);
        add(0, OP_J, 0, 1, C_IDLE);
        for (int i = 0; i < plan.size(); i++) begin
            bus.enable = plan[i].en; bus.opcode = plan[i].op; bus.zero = plan[i].z; bus.mem_ready = plan[i].rdy;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_checks++;
            if (ctrl !== exp_v) begin n_fail++; $display("FAIL branch_jump step %0d: ctrl=%b required %b", i, ctrl, exp_v); end
            @(posedge clk); #1;
        end
        plan.delete();
        exp_cnt = exp_cnt + 2'd3;
        n_checks++;
        if (bus.instr_retired !== exp_cnt) begin n_fail++; $display("FAIL branch_jump_count: cnt=%0d required %0d", bus.instr_retired, exp_cnt); end
        $display("test_branch_jump: cnt=%0d", bus.instr_retired);
    endtask

    task automatic test_illegal_timeout();
        add(1, OP_BAD, 0, 1, C_IDLE);    add(1, OP_BAD, 0, 1, C_FETCH_R);
        add(1, OP_BAD, 0, 0, C_DECODE);  add(1, OP_BAD, 0, 0, C_FETCH_W | C_ILL);
        add(1, OP_BAD, 0, 0, C_FETCH_W); add(1, OP_BAD, 0, 0, C_FETCH_W);
        add(0, OP_BAD, 0, 0, C_FETCH_W); add(0, OP_BAD, 0, 0, C_IDLE | C_BERR);
        add(0, OP_BAD, 0, 0, C_IDLE);
        for (int i = 0; i < plan.size(); i++) begin
            bus.enable = plan[i].en; bus.opcode = plan[i].op; bus.zero = plan[i].z; bus.mem_ready = plan[i].rdy;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_checks++;
            if (ctrl !== exp_v) begin n_fail++; $display("FAIL illegal_timeout step %0d: ctrl=%b required %b", i, ctrl, exp_v); end
            @(posedge clk); #1;
        end
        plan.delete();
        n_checks++;
        if (bus.instr_retired !== exp_cnt) begin n_fail++; $display("FAIL illegal_timeout_count: cnt=%0d required %0d", bus.instr_retired, exp_cnt); end
        $display("test_illegal_timeout: cnt=%0d", bus.instr_retired);
    endtask

    task automatic test_back_to_back_wrap();
        int jumps;
        jumps = 15 - int'(exp_cnt);
        add(1, OP_J, 0, 1, C_IDLE);
        for (int k = 0; k < jumps; k++) begin
            add(1, OP_J, 0, 1, C_FETCH_R); add(1, OP_J, 0, 1, C_DECODE); add(1, OP_J, 0, 1, C_JUMP);
        end
        for (int i = 0; i < plan.size(); i++) begin
            bus.enable = plan[i].en; bus.opcode = plan[i].op; bus.zero = plan[i].z; bus.mem_ready = plan[i].rdy;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_checks++;
            if (ctrl !== exp_v) begin n_fail++; $display("FAIL back_to_back step %0d: ctrl=%b required %b", i, ctrl, exp_v); end
            @(posedge clk); #1;
        end
        plan.delete();
        exp_cnt = 4'd15;
        n_checks++;
        if (bus.instr_retired !== exp_cnt) begin n_fail++; $display("FAIL count_at_max: cnt=%0d required %0d", bus.instr_retired, exp_cnt); end
        add(1, OP_I, 0, 1, C_FETCH_R); add(1, OP_I, 0, 1, C_DECODE);
        add(0, OP_I, 0, 1, C_EXEC_I);  add(0, OP_I, 0, 1, C_WB_ALU);
        add(0, OP_I, 0, 1, C_IDLE);
        for (int i = 0; i < plan.size(); i++) begin
            bus.enable = plan[i].en; bus.opcode = plan[i].op; bus.zero = plan[i].z; bus.mem_ready = plan[i].rdy;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_checks++;
            if (ctrl !== exp_v) begin n_fail++; $display("FAIL wrap_exec_i step %0d: ctrl=%b required %b", i, ctrl, exp_v); end
            @(posedge clk); #1;
        end
        plan.delete();
        exp_cnt = exp_cnt + 1'b1;
        n_checks++;
        if (bus.instr_retired !== exp_cnt) begin n_fail++; $display("FAIL count_wrap: cnt=%0d required %0d", bus.instr_retired, exp_cnt); end
        $display("test_back_to_back_wrap: cnt=%0d", bus.instr_retired);
    endtask

    task automatic test_async_reset();
        add(1, OP_J, 0, 1, C_IDLE);     add(1, OP_J, 0, 1, C_FETCH_R);
        add(1, OP_J, 0, 1, C_DECODE);   add(1, OP_J, 0, 1, C_JUMP);
        add(1, OP_LD, 0, 1, C_FETCH_R); add(1, OP_LD, 0, 1, C_DECODE);
        add(1, OP_LD, 0, 1, C_MEM_ADDR); add(1, OP_LD, 0, 0, C_MEM_RD);
        for (int i = 0; i < plan.size(); i++) begin
            bus.enable = plan[i].en; bus.opcode = plan[i].op; bus.zero = plan[i].z; bus.mem_ready = plan[i].rdy;
            sb.push_back(plan[i].exp);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_checks++;
            if (ctrl !== exp_v) begin n_fail++; $display("FAIL pre_reset step %0d: ctrl=%b required %b", i, ctrl, exp_v); end
            @(posedge clk); #1;
        end
        plan.delete();
        exp_cnt = exp_cnt + 1'b1;
        n_checks++;
        if (bus.instr_retired !== exp_cnt) begin n_fail++; $display("FAIL pre_reset_count: cnt=%0d required %0d", bus.instr_retired, exp_cnt); end
        @(negedge clk);
        n_checks++;
        if (ctrl !== C_MEM_RD) begin n_fail++; $display("FAIL mid_mem_rd: ctrl=%b required %b", ctrl, C_MEM_RD); end
        #2 arst = 1'b1;
        #1;
        exp_cnt = '0;
        n_checks++;
        if (ctrl !== C_IDLE || bus.instr_retired !== exp_cnt) begin
            n_fail++;
            $display("FAIL async_reset: ctrl=%b cnt=%0d required ctrl=%b cnt=0", ctrl, bus.instr_retired, C_IDLE);
        end
        @(posedge clk); #1;
        arst = 1'b0;
        bus.enable = 1'b0;
        bus.mem_ready = 1'b1;
        sb.push_back(C_IDLE);
        @(negedge clk);
        exp_v = sb.pop_front();
        n_checks++;
        if (ctrl !== exp_v || bus.instr_retired !== exp_cnt) begin
            n_fail++;
            $display("FAIL after_release: ctrl=%b cnt=%0d required ctrl=%b cnt=0", ctrl, bus.instr_retired, exp_v);
        end
        $display("test_async_reset: ctrl=%b cnt=%0d", ctrl, bus.instr_retired);
    endtask

    initial begin
        bus.enable = 1'b0; bus.opcode = 7'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        test_reset();
        test_alu_r();
        test_load_store();
        test_branch_jump();
        test_illegal_timeout();
        test_back_to_back_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog expired");
    end
endmodule
